// File: rtl/axi_rd_arb_pkg.sv
// Shared AXI widths, response codes and the AR payload bundle
// used by the read-side arbiter and its reusable round-robin core.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_USER_WIDTH
`define AXI_USER_WIDTH 1
`endif
`ifndef AXI_DN_ID_WIDTH
`define AXI_DN_ID_WIDTH(idx_w) (`AXI_ID_WIDTH + (idx_w))
`endif

package axi_rd_arb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int OUTS_W = 4;

  typedef struct packed {
    logic [`AXI_ADDR_WIDTH-1:0]  addr;
    logic [`AXI_LEN_WIDTH-1:0]   len;
    logic [`AXI_SIZE_WIDTH-1:0]  size;
    logic [`AXI_BURST_WIDTH-1:0] burst;
    logic [`AXI_USER_WIDTH-1:0]  user;
  } ar_pld_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr.
// Shared by the read arbiter and the planned write-side arbiter.
module rr_arb #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    // Walk from farthest to nearest so the closest requester wins.
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt      = '0;
        gnt[j]   = 1'b1;
        gnt_idx  = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arb.sv
// N-to-1 AXI read arbiter: round-robin AR into one output slot,
// per-master outstanding limits, R routed back by ID index bits.
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int NUM_MST  = 2,
  parameter int IDX_W    = $clog2(NUM_MST),
  parameter int MAX_OUTS = 4
) (
  input  logic clk,
  input  logic rst_n,

  input  logic [NUM_MST*`AXI_ID_WIDTH-1:0]    up_arid,
  input  logic [NUM_MST*`AXI_ADDR_WIDTH-1:0]  up_araddr,
  input  logic [NUM_MST*`AXI_LEN_WIDTH-1:0]   up_arlen,
  input  logic [NUM_MST*`AXI_SIZE_WIDTH-1:0]  up_arsize,
  input  logic [NUM_MST*`AXI_BURST_WIDTH-1:0] up_arburst,
  input  logic [NUM_MST*`AXI_USER_WIDTH-1:0]  up_aruser,
  input  logic [NUM_MST-1:0]                  up_arvalid,
  output logic [NUM_MST-1:0]                  up_arready,

  output logic [NUM_MST*`AXI_ID_WIDTH-1:0]    up_rid,
  output logic [NUM_MST*`AXI_DATA_WIDTH-1:0]  up_rdata,
  output logic [NUM_MST*`AXI_RESP_WIDTH-1:0]  up_rresp,
  output logic [NUM_MST*`AXI_USER_WIDTH-1:0]  up_ruser,
  output logic [NUM_MST-1:0]                  up_rlast,
  output logic [NUM_MST-1:0]                  up_rvalid,
  input  logic [NUM_MST-1:0]                  up_rready,

  output logic [`AXI_DN_ID_WIDTH(IDX_W)-1:0]  dn_arid,
  output logic [`AXI_ADDR_WIDTH-1:0]          dn_araddr,
  output logic [`AXI_LEN_WIDTH-1:0]           dn_arlen,
  output logic [`AXI_SIZE_WIDTH-1:0]          dn_arsize,
  output logic [`AXI_BURST_WIDTH-1:0]         dn_arburst,
  output logic [`AXI_USER_WIDTH-1:0]          dn_aruser,
  output logic                                dn_arvalid,
  input  logic                                dn_arready,

  input  logic [`AXI_DN_ID_WIDTH(IDX_W)-1:0]  dn_rid,
  input  logic [`AXI_DATA_WIDTH-1:0]          dn_rdata,
  input  logic [`AXI_RESP_WIDTH-1:0]          dn_rresp,
  input  logic                                dn_rlast,
  input  logic [`AXI_USER_WIDTH-1:0]          dn_ruser,
  input  logic                                dn_rvalid,
  output logic                                dn_rready,

  output logic                                rd_err
);

  localparam int IDW = `AXI_ID_WIDTH;
  localparam int AW  = `AXI_ADDR_WIDTH;
  localparam int LW  = `AXI_LEN_WIDTH;
  localparam int SW  = `AXI_SIZE_WIDTH;
  localparam int BW  = `AXI_BURST_WIDTH;
  localparam int UW  = `AXI_USER_WIDTH;
  localparam int DIW = `AXI_DN_ID_WIDTH(IDX_W);

  logic [NUM_MST-1:0] elig;
  logic [NUM_MST-1:0] gnt;
  logic [IDX_W-1:0]   w;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               slot_free;
  logic               grant;

  logic               arvalid_q;
  logic [DIW-1:0]     arid_q;
  ar_pld_t            pld_q, pld_w;

  logic [OUTS_W-1:0]  outs_q [NUM_MST];
  logic [OUTS_W-1:0]  outs_d [NUM_MST];

  logic [IDX_W-1:0]   idx;
  logic               bad;
  logic               r_hs;
  logic               rd_err_q;

  // AR side
  always_comb begin
    for (int i = 0; i < NUM_MST; i++)
      elig[i] = up_arvalid[i] && (outs_q[i] < OUTS_W'(MAX_OUTS));
  end

  rr_arb #(.N(NUM_MST)) u_rr (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (w)
  );

  assign slot_free  = !arvalid_q || dn_arready;
  assign grant      = rst_n && slot_free && (|elig);
  assign up_arready = grant ? gnt : '0;

  always_comb begin
    pld_w.addr  = up_araddr[int'(w)*AW +: AW];
    pld_w.len   = up_arlen[int'(w)*LW +: LW];
    pld_w.size  = up_arsize[int'(w)*SW +: SW];
    pld_w.burst = up_arburst[int'(w)*BW +: BW];
    pld_w.user  = up_aruser[int'(w)*UW +: UW];
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      if (w == IDX_W'(NUM_MST - 1)) rr_ptr_d = '0;
      else                          rr_ptr_d = w + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      pld_q     <= '0;
      rr_ptr_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        arvalid_q <= 1'b1;
        arid_q    <= {w, up_arid[int'(w)*IDW +: IDW]};
        pld_q     <= pld_w;
      end else if (dn_arready) begin
        arvalid_q <= 1'b0;
      end
    end
  end

  assign dn_arvalid = arvalid_q;
  assign dn_arid    = arid_q;
  assign dn_araddr  = pld_q.addr;
  assign dn_arlen   = pld_q.len;
  assign dn_arsize  = pld_q.size;
  assign dn_arburst = pld_q.burst;
  assign dn_aruser  = pld_q.user;

  // R side
  assign idx = dn_rid[DIW-1 -: IDX_W];
  assign bad = int'(idx) >= NUM_MST;

  always_comb begin
    up_rvalid = '0;
    dn_rready = 1'b1;
    for (int i = 0; i < NUM_MST; i++) begin
      if (idx == IDX_W'(i)) begin
        up_rvalid[i] = dn_rvalid;
        dn_rready    = up_rready[i];
      end
    end
  end

  assign up_rid   = {NUM_MST{dn_rid[IDW-1:0]}};
  assign up_rdata = {NUM_MST{dn_rdata}};
  assign up_rresp = {NUM_MST{dn_rresp}};
  assign up_ruser = {NUM_MST{dn_ruser}};
  assign up_rlast = {NUM_MST{dn_rlast}};

  assign r_hs = dn_rvalid && dn_rready;

  // Beats arriving after a reset may find the counter already at zero.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      logic dec;
      dec = r_hs && dn_rlast && !bad && (idx == IDX_W'(i))
            && (outs_q[i] != '0);
      outs_d[i] = outs_q[i];
      if (up_arready[i] && !dec)      outs_d[i] = outs_q[i] + 1'b1;
      else if (!up_arready[i] && dec) outs_d[i] = outs_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MST; i++) outs_q[i] <= '0;
      rd_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MST; i++) outs_q[i] <= outs_d[i];
      if (dn_rvalid && bad) rd_err_q <= 1'b1;
    end
  end

  assign rd_err = rd_err_q;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Bench for axi_rd_arb: 3 masters, 4 outstanding each, AR scoreboard
// queue plus directed R routing, stall and bad-index cases.
module tb_axi_rd_arb;

  localparam int NM  = 3;
  localparam int IXW = 2;
  localparam int MO  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [NM*4-1:0]  up_arid;
  logic [NM*32-1:0] up_araddr;
  logic [NM*8-1:0]  up_arlen;
  logic [NM*3-1:0]  up_arsize;
  logic [NM*2-1:0]  up_arburst;
  logic [NM-1:0]    up_aruser;
  logic [NM-1:0]    up_arvalid;
  logic [NM-1:0]    up_arready;
  logic [NM*4-1:0]  up_rid;
  logic [NM*32-1:0] up_rdata;
  logic [NM*2-1:0]  up_rresp;
  logic [NM-1:0]    up_ruser;
  logic [NM-1:0]    up_rlast;
  logic [NM-1:0]    up_rvalid;
  logic [NM-1:0]    up_rready;
  logic [5:0]       dn_arid;
  logic [31:0]      dn_araddr;
  logic [7:0]       dn_arlen;
  logic [2:0]       dn_arsize;
  logic [1:0]       dn_arburst;
  logic [0:0]       dn_aruser;
  logic             dn_arvalid;
  logic             dn_arready;
  logic [5:0]       dn_rid;
  logic [31:0]      dn_rdata;
  logic [1:0]       dn_rresp;
  logic             dn_rlast;
  logic [0:0]       dn_ruser;
  logic             dn_rvalid;
  logic             dn_rready;
  logic             rd_err;

  axi_rd_arb #(.NUM_MST(NM), .IDX_W(IXW), .MAX_OUTS(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_arid(up_arid), .up_araddr(up_araddr), .up_arlen(up_arlen),
    .up_arsize(up_arsize), .up_arburst(up_arburst),
    .up_aruser(up_aruser), .up_arvalid(up_arvalid),
    .up_arready(up_arready),
    .up_rid(up_rid), .up_rdata(up_rdata), .up_rresp(up_rresp),
    .up_ruser(up_ruser), .up_rlast(up_rlast), .up_rvalid(up_rvalid),
    .up_rready(up_rready),
    .dn_arid(dn_arid), .dn_araddr(dn_araddr), .dn_arlen(dn_arlen),
    .dn_arsize(dn_arsize), .dn_arburst(dn_arburst),
    .dn_aruser(dn_aruser), .dn_arvalid(dn_arvalid),
    .dn_arready(dn_arready),
    .dn_rid(dn_rid), .dn_rdata(dn_rdata), .dn_rresp(dn_rresp),
    .dn_rlast(dn_rlast), .dn_ruser(dn_ruser), .dn_rvalid(dn_rvalid),
    .dn_rready(dn_rready), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  id;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] id, input logic [31:0] a);
    exp_t x;
    x.id   = id;
    x.addr = a;
    q.push_back(x);
  endtask

  task automatic set_ar(input int m, input logic v,
                        input logic [3:0] id, input logic [31:0] a);
    up_arvalid[m]       = v;
    up_arid[m*4 +: 4]   = id;
    up_araddr[m*32 +: 32] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    up_arvalid = '0;
    up_rready  = '0;
    dn_rvalid  = 1'b0;
    dn_rlast   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // AR scoreboard: pop on every downstream handshake
  always @(negedge clk) begin
    if (rst_n && dn_arvalid && dn_arready) begin
      if (q.size() == 0) begin
        check("ar_unexpected", {58'd0, dn_arid}, 64'hFFFF);
      end else begin
        e = q.pop_front();
        check("dn_arid", dn_arid, e.id);
        check("dn_araddr", dn_araddr, e.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    int beat;
    up_arid = '0; up_araddr = '0; up_arlen = '0; up_arsize = '0;
    up_arburst = '0; up_aruser = '0; up_arvalid = '0; up_rready = '0;
    dn_arready = 1'b1; dn_rid = '0; dn_rdata = '0; dn_rresp = '0;
    dn_rlast = 1'b0; dn_ruser = '0; dn_rvalid = 1'b0;

    // reset release, idle
    do_reset();
    @(negedge clk);
    check("rst_arvalid", dn_arvalid, 0);
    check("rst_arready", up_arready, 0);
    check("rst_err", rd_err, 0);
    check("rst_araddr", dn_araddr, 0);

    // two masters alternate, one grant per cycle
    step();
    set_ar(0, 1, 4'd3, 32'h100);
    set_ar(1, 1, 4'd5, 32'h200);
    for (int k = 0; k < 3; k++) begin
      push(6'h03, 32'h100);
      push(6'h15, 32'h200);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("alt_arready", up_arready, (k % 2) ? 3'b010 : 3'b001);
      step();
    end
    up_arvalid = '0;
    repeat (3) step();
    check("alt_qempty", q.size(), 0);

    // outstanding limit on master 0
    do_reset();
    set_ar(0, 1, 4'd1, 32'h300);
    for (int k = 0; k < 5; k++) push(6'h01, 32'h300);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lim_arready", up_arready, 3'b001);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lim_blocked", up_arready, 3'b000);
      step();
    end
    dn_rvalid = 1'b1; dn_rid = 6'h01; dn_rlast = 1'b1;
    up_rready = 3'b001;
    @(negedge clk);
    check("lim_rvalid", up_rvalid, 3'b001);
    check("lim_rready", dn_rready, 1);
    check("lim_still", up_arready, 3'b000);
    step();
    dn_rvalid = 1'b0; dn_rlast = 1'b0; up_rready = '0;
    @(negedge clk);
    check("lim_regrant", up_arready, 3'b001);
    step();
    up_arvalid = '0;
    repeat (3) step();
    check("lim_qempty", q.size(), 0);

    // 4-beat burst to master 1 with backpressure
    do_reset();
    set_ar(1, 1, 4'd5, 32'h600);
    push(6'h15, 32'h600);
    push(6'h15, 32'h600);
    repeat (2) step();
    up_arvalid = '0;
    repeat (2) step();
    check("bst_outs0", dut.outs_q[1], 2);
    pat  = 5'b11101;
    beat = 0;
    for (int c = 0; c < 5; c++) begin
      dn_rvalid = 1'b1;
      dn_rid    = 6'h15;
      dn_rlast  = (beat == 3);
      dn_rdata  = 32'hA0 + beat;
      up_rready = {1'b0, pat[c], 1'b0};
      @(negedge clk);
      check("bst_rvalid", up_rvalid, 3'b010);
      check("bst_rid", up_rid[4 +: 4], 5);
      check("bst_rdata", up_rdata[32 +: 32], 32'hA0 + beat);
      check("bst_rready", dn_rready, pat[c]);
      check("bst_outs", dut.outs_q[1], 2);
      step();
      if (pat[c]) beat++;
    end
    dn_rvalid = 1'b0; dn_rlast = 1'b0; up_rready = '0;
    @(negedge clk);
    check("bst_outs_dec", dut.outs_q[1], 1);
    check("bst_qempty", q.size(), 0);

    // downstream stall holds slot and pointer
    do_reset();
    dn_arready = 1'b0;
    set_ar(0, 1, 4'd2, 32'h400);
    set_ar(1, 1, 4'd6, 32'h500);
    push(6'h02, 32'h400);
    push(6'h16, 32'h500);
    @(negedge clk);
    check("stl_first", up_arready, 3'b001);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stl_arready", up_arready, 3'b000);
      check("stl_arvalid", dn_arvalid, 1);
      check("stl_arid", dn_arid, 6'h02);
      check("stl_araddr", dn_araddr, 32'h400);
      check("stl_ptr", dut.rr_ptr_q, 1);
      step();
    end
    dn_arready = 1'b1;
    @(negedge clk);
    check("stl_reload", up_arready, 3'b010);
    step();
    up_arvalid = '0;
    repeat (3) step();
    check("stl_qempty", q.size(), 0);

    // bad index sunk, sticky error until reset
    dn_rvalid = 1'b1; dn_rid = {2'd3, 4'd7}; dn_rlast = 1'b1;
    up_rready = '0;
    @(negedge clk);
    check("bad_rready", dn_rready, 1);
    check("bad_rvalid", up_rvalid, 3'b000);
    check("bad_err_pre", rd_err, 0);
    step();
    dn_rvalid = 1'b0; dn_rlast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bad_err", rd_err, 1);
      step();
    end
    set_ar(0, 1, 4'd1, 32'h700);
    rst_n = 1'b0;
    #1;
    check("rst_err_clr", rd_err, 0);
    check("rst_arready_gate", up_arready, 3'b000);
    up_arvalid = '0;
    step();
    rst_n = 1'b1;
    step();

    // late rlast after reset: routed, counter stays at zero
    dn_rvalid = 1'b1; dn_rid = 6'h23; dn_rlast = 1'b1;
    up_rready = 3'b100;
    @(negedge clk);
    check("late_rvalid", up_rvalid, 3'b100);
    step();
    dn_rvalid = 1'b0; dn_rlast = 1'b0; up_rready = '0;
    @(negedge clk);
    check("late_outs", dut.outs_q[2], 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
